router_drain_sched: RTL and testbench



---
 rtl/router_pkg.sv | 34 +++
 rtl/router_drain_sched_rr_arbiter.sv | 34 +++
 rtl/router_drain_sched.sv | 146 ++++++++++++++
 tb/tb_router_drain_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router output side: scheduler state encoding,
// header length field position, default sizing and address-to-port mapping.
// Latency: n/a (constants and pure functions only). Backpressure: n/a.
package router_pkg;

  // Number of router output FIFOs and the width of a port index
  localparam int NPORTS = 3;
  localparam int PW     = 2;

  // Default byte width and starvation limit for the drain scheduler
  localparam int DATA_W        = 8;
  localparam int DRAIN_TIMEOUT = 32;

  // Header layout: [7:2] payload length, [1:0] destination address
  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;

  // Drain scheduler FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;
  localparam logic [1:0] S_LAST = 2'd3;

  // Header address field to output port; address 3 is not a port and
  // reports invalid (router_fsm drops such packets)
  function automatic logic [PW-1:0] addr_to_port(input logic [1:0] addr);
    return (addr == 2'd3) ? '0 : addr;
  endfunction

  function automatic logic addr_valid(input logic [1:0] addr);
    return addr != 2'd3;
  endfunction

endpackage

// File: rtl/router_drain_sched_rr_arbiter.sv
// Round-robin port picker: first requesting port after last_grant, wrapping.
// Latency: combinational. Backpressure: none; the caller decides when to latch.
// Ports: req (per-port request), last_grant (pointer held by the parent),
//        grant (chosen index, last_grant when idle), any_req (|req).
module rr_arbiter
  import router_pkg::*;
#(
  parameter int N = NPORTS,
  parameter int W = PW
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic [W-1:0] grant,
  output logic         any_req
);

  logic [W-1:0] cand;

  // Walk from the farthest candidate to the nearest so the port closest
  // after last_grant is the one left standing.
  always_comb begin
    grant   = last_grant;
    any_req = 1'b0;
    cand    = '0;
    for (int i = N; i >= 1; i--) begin
      cand = W'((int'(last_grant) + i) % N);
      if (req[cand]) begin
        grant   = cand;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_drain_sched.sv
// Drains one whole packet at a time from the router FIFOs onto a framed egress stream.
// Latency: FIFO read to egress valid 2 cycles; 1 byte every 2 cycles at best.
// Backpressure: FIFO reads stall while the egress register is full and not accepted.
// Ports: clk/reset (sync, active-high); vldout/data_in_0..2 from the router FIFOs;
//        read_enb one-hot read strobes; out_data/out_valid/out_ready/out_sop/out_eop
//        egress stream; out_port owning port; busy packet in flight; out_abort timeout pulse.
module router_drain_sched
  import router_pkg::*;
#(
  parameter int DW      = DATA_W,
  parameter int LEN_MSB = HDR_LEN_MSB,
  parameter int LEN_LSB = HDR_LEN_LSB,
  parameter int TIMEOUT = DRAIN_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NPORTS-1:0] vldout,
  input  logic [DW-1:0]     data_in_0,
  input  logic [DW-1:0]     data_in_1,
  input  logic [DW-1:0]     data_in_2,
  output logic [NPORTS-1:0] read_enb,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [PW-1:0]     out_port,
  output logic              busy,
  output logic              out_abort
);

  localparam int LW = LEN_MSB - LEN_LSB + 1;
  localparam int RW = LW + 1;              // payload length + parity byte
  localparam int SW = $clog2(TIMEOUT + 1);

  logic [1:0]    state;
  logic [PW-1:0] last_grant;
  logic          first;
  logic [RW-1:0] remaining;
  logic [SW-1:0] starve;

  logic [PW-1:0] arb_grant;
  logic          any_req;
  logic          free;
  logic          rd_fire;
  logic          cap_eop;
  logic [DW-1:0] cap_data;

  rr_arbiter #(.N(NPORTS), .W(PW)) u_arb (
    .req        (vldout),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .any_req    (any_req)
  );

  // The granted port is out_port for the whole packet.
  always_comb begin
    cap_data = '0;
    case (out_port)
      2'd0:    cap_data = data_in_0;
      2'd1:    cap_data = data_in_1;
      2'd2:    cap_data = data_in_2;
      default: cap_data = '0;
    endcase
  end

  // Reading only when the egress register will be empty by the time CAP
  // loads means CAP never has to wait.
  assign free     = !out_valid || out_ready;
  assign rd_fire  = (state == S_RD) && vldout[out_port] && free;
  assign read_enb = rd_fire ? (NPORTS'(1) << out_port) : '0;
  // remaining still holds the count before this byte; 1 left means parity.
  assign cap_eop  = !first && (remaining == RW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= PW'(NPORTS - 1);
      first      <= 1'b0;
      remaining  <= '0;
      starve     <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_port   <= '0;
      busy       <= 1'b0;
      out_abort  <= 1'b0;
    end else begin
      out_abort <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (any_req) begin
            out_port   <= arb_grant;
            last_grant <= arb_grant;
            first      <= 1'b1;
            busy       <= 1'b1;
            starve     <= '0;
            state      <= S_RD;
          end
        end

        S_RD: begin
          if (rd_fire) begin
            starve <= '0;
            state  <= S_CAP;
          end else if (!vldout[out_port]) begin
            if (starve == SW'(TIMEOUT - 1)) begin
              out_abort <= 1'b1;
              busy      <= 1'b0;
              starve    <= '0;
              state     <= S_IDLE;
            end else begin
              starve <= starve + SW'(1);
            end
          end
        end

        S_CAP: begin
          out_data  <= cap_data;
          out_valid <= 1'b1;
          out_sop   <= first;
          out_eop   <= cap_eop;
          first     <= 1'b0;
          remaining <= first ? ({1'b0, cap_data[LEN_MSB:LEN_LSB]} + RW'(1))
                             : (remaining - RW'(1));
          state     <= cap_eop ? S_LAST : S_RD;
        end

        S_LAST: begin
          if (out_valid && out_ready) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_drain_sched.sv
module tb_router_drain_sched;

  logic       clk;
  logic       reset;
  logic [2:0] vldout;
  logic [7:0] din [3];
  logic [2:0] read_enb;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sop;
  logic       out_eop;
  logic [1:0] out_port;
  logic       busy;
  logic       out_abort;

  router_drain_sched dut (
    .clk       (clk),
    .reset     (reset),
    .vldout    (vldout),
    .data_in_0 (din[0]),
    .data_in_1 (din[1]),
    .data_in_2 (din[2]),
    .read_enb  (read_enb),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_port  (out_port),
    .busy      (busy),
    .out_abort (out_abort)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Router FIFO stand-in: data appears one cycle after the read strobe.
  logic [7:0] fmem [3][256];
  logic [7:0] wr_ptr [3];
  logic [7:0] rd_ptr [3];
  logic       flush;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (flush) begin
        rd_ptr[i] <= wr_ptr[i];
      end else if (read_enb[i]) begin
        din[i]    <= fmem[i][rd_ptr[i]];
        rd_ptr[i] <= rd_ptr[i] + 8'd1;
      end
    end
  end

  assign vldout = {wr_ptr[2] != rd_ptr[2], wr_ptr[1] != rd_ptr[1], wr_ptr[0] != rd_ptr[0]};

  // Egress sink log: {sop, eop, port, data} for every accepted beat.
  logic [11:0] blog [256];
  int nbeats     = 0;
  int abort_cnt  = 0;
  logic abort_busy = 1'b1;
  int rd_cnt [3] = '{0, 0, 0};
  int rd_bad     = 0;

  always @(negedge clk) begin
    if (out_valid && out_ready && nbeats < 256) begin
      blog[nbeats] = {out_sop, out_eop, out_port, out_data};
      nbeats = nbeats + 1;
    end
    if (out_abort) begin
      abort_cnt  = abort_cnt + 1;
      abort_busy = busy;
    end
    for (int i = 0; i < 3; i++) if (read_enb[i]) rd_cnt[i] = rd_cnt[i] + 1;
    if (read_enb != 3'b000 && (read_enb != (3'b001 << out_port) || !busy)) rd_bad = rd_bad + 1;
  end

  int total = 0;
  int bad   = 0;
  int rdx   = 0;
  int k;
  int base;
  int r0, r1, r2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int p, input logic [7:0] b);
    fmem[p][wr_ptr[p]] = b;
    wr_ptr[p] = wr_ptr[p] + 8'd1;
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (nbeats < rdx + n && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    check(tag, 32'(nbeats - rdx >= n), 32'd1);
  endtask

  task automatic exp_beat(input string tag, input logic s, input logic e,
                          input logic [1:0] p, input logic [7:0] d);
    logic [11:0] got;
    got = (rdx < nbeats) ? blog[rdx] : 12'hFFF;
    check(tag, 32'(got), 32'({s, e, p, d}));
    rdx++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    flush = 1'b0;
    @(negedge clk); #1;
    rdx = nbeats;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) wr_ptr[i] = 8'd0;

    // Reset state
    do_reset();
    check("rst_outputs", 32'({read_enb, out_data, out_valid, out_sop, out_eop, out_port, busy, out_abort}), 32'd0);
    check("rst_vldout", 32'(vldout), 32'd0);

    // 1: single 5-byte packet on port 1
    r0 = rd_cnt[0]; r1 = rd_cnt[1]; r2 = rd_cnt[2];
    push(1, 8'h0D); push(1, 8'h11); push(1, 8'h22); push(1, 8'h33); push(1, 8'hA5);
    wait_beats("t1_wait", 5, 100);
    exp_beat("t1_b0", 1'b1, 1'b0, 2'd1, 8'h0D);
    exp_beat("t1_b1", 1'b0, 1'b0, 2'd1, 8'h11);
    exp_beat("t1_b2", 1'b0, 1'b0, 2'd1, 8'h22);
    exp_beat("t1_b3", 1'b0, 1'b0, 2'd1, 8'h33);
    exp_beat("t1_b4", 1'b0, 1'b1, 2'd1, 8'hA5);
    repeat (2) begin @(negedge clk); #1; end
    check("t1_rd_port1", 32'(rd_cnt[1] - r1), 32'd5);
    check("t1_rd_other", 32'((rd_cnt[0] - r0) + (rd_cnt[2] - r2)), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);

    // 2: all three ports request at once, then port 0 refills
    do_reset();
    push(0, 8'h00); push(0, 8'h00);
    push(1, 8'h01); push(1, 8'h01);
    push(2, 8'h02); push(2, 8'h02);
    wait_beats("t2_wait_p0", 2, 100);
    push(0, 8'h00); push(0, 8'h00);
    wait_beats("t2_wait_all", 8, 200);
    exp_beat("t2_b0", 1'b1, 1'b0, 2'd0, 8'h00);
    exp_beat("t2_b1", 1'b0, 1'b1, 2'd0, 8'h00);
    exp_beat("t2_b2", 1'b1, 1'b0, 2'd1, 8'h01);
    exp_beat("t2_b3", 1'b0, 1'b1, 2'd1, 8'h01);
    exp_beat("t2_b4", 1'b1, 1'b0, 2'd2, 8'h02);
    exp_beat("t2_b5", 1'b0, 1'b1, 2'd2, 8'h02);
    exp_beat("t2_b6", 1'b1, 1'b0, 2'd0, 8'h00);
    exp_beat("t2_b7", 1'b0, 1'b1, 2'd0, 8'h00);

    // 3: sink stalls 5 cycles after beat 2 of a 6-byte packet
    repeat (2) begin @(negedge clk); #1; end
    base = rdx;
    push(0, 8'h10); push(0, 8'h01); push(0, 8'h02); push(0, 8'h03); push(0, 8'h04); push(0, 8'h14);
    wait_beats("t3_wait2", 2, 100);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check("t3_stall_no_rd", 32'(read_enb), 32'd0);
      if (c >= 1) check("t3_stall_hold", 32'({out_valid, out_sop, out_eop, out_data}), 32'({3'b100, 8'h02}));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_beats("t3_wait6", 6, 100);
    repeat (4) begin @(negedge clk); #1; end
    check("t3_count", 32'(nbeats - base), 32'd6);
    exp_beat("t3_b0", 1'b1, 1'b0, 2'd0, 8'h10);
    exp_beat("t3_b1", 1'b0, 1'b0, 2'd0, 8'h01);
    exp_beat("t3_b2", 1'b0, 1'b0, 2'd0, 8'h02);
    exp_beat("t3_b3", 1'b0, 1'b0, 2'd0, 8'h03);
    exp_beat("t3_b4", 1'b0, 1'b0, 2'd0, 8'h04);
    exp_beat("t3_b5", 1'b0, 1'b1, 2'd0, 8'h14);

    // 4: zero-length packet on port 2
    push(2, 8'h02); push(2, 8'h02);
    wait_beats("t4_wait", 2, 100);
    check("t4_busy_at_accept", 32'(busy), 32'd1);
    @(negedge clk); #1;
    check("t4_busy_after", 32'({busy, out_valid}), 32'd0);
    exp_beat("t4_b0", 1'b1, 1'b0, 2'd2, 8'h02);
    exp_beat("t4_b1", 1'b0, 1'b1, 2'd2, 8'h02);

    // 5: port 0 starves mid-packet while port 1 waits
    base = abort_cnt;
    push(0, 8'h0C); push(0, 8'hB1); push(0, 8'hB2);
    push(1, 8'h05); push(1, 8'h77); push(1, 8'h72);
    wait_beats("t5_wait_p0", 3, 100);
    exp_beat("t5_b0", 1'b1, 1'b0, 2'd0, 8'h0C);
    exp_beat("t5_b1", 1'b0, 1'b0, 2'd0, 8'hB1);
    exp_beat("t5_b2", 1'b0, 1'b0, 2'd0, 8'hB2);
    k = 0;
    while (abort_cnt == base && k < 100) begin @(negedge clk); #1; k++; end
    check("t5_abort_seen", 32'(abort_cnt - base), 32'd1);
    check("t5_abort_busy", 32'(abort_busy), 32'd0);
    wait_beats("t5_wait_p1", 3, 100);
    exp_beat("t5_b3", 1'b1, 1'b0, 2'd1, 8'h05);
    exp_beat("t5_b4", 1'b0, 1'b0, 2'd1, 8'h77);
    exp_beat("t5_b5", 1'b0, 1'b1, 2'd1, 8'h72);
    check("t5_abort_once", 32'(abort_cnt - base), 32'd1);

    // 6: reset lands in the middle of a packet
    repeat (2) begin @(negedge clk); #1; end
    push(1, 8'h0D); push(1, 8'h11); push(1, 8'h22); push(1, 8'h33); push(1, 8'hA5);
    wait_beats("t6_wait2", 2, 100);
    @(posedge clk); #1;
    reset = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    flush = 1'b0;
    @(negedge clk); #1;
    check("t6_rst_outputs", 32'({read_enb, out_data, out_valid, out_sop, out_eop, out_port, busy, out_abort}), 32'd0);
    rdx = nbeats;
    push(2, 8'h02); push(2, 8'h02);
    push(1, 8'h01); push(1, 8'h01);
    wait_beats("t6_wait", 4, 100);
    exp_beat("t6_b0", 1'b1, 1'b0, 2'd1, 8'h01);
    exp_beat("t6_b1", 1'b0, 1'b1, 2'd1, 8'h01);
    exp_beat("t6_b2", 1'b1, 1'b0, 2'd2, 8'h02);
    exp_beat("t6_b3", 1'b0, 1'b1, 2'd2, 8'h02);

    check("read_enb_legal", 32'(rd_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

endmodule
